// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// RV32I opcode constants, ALUControl codes and datapath mux-select codes.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ERROR    = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; anything without a special
  // format (loads, OP-IMM, R-type, illegal) falls back to I-type.
  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mctrl_alu_dec.sv
// Combinational funct3/funct7 -> ALUControl decode for R-type and OP-IMM.
// Subtract is only allowed when sub_en_i is set (OPCODE[5], i.e. R-type),
// so an OP-IMM immediate with bit 30 set still decodes as add.
module mctrl_alu_dec
  import mctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       sub_en_i,
  output logic [2:0] alu_ctrl_o
);

  // Map funct3 to the ALU operation; unsupported encodings fall back to add.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_ctrl_o = (funct7_i && sub_en_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ctrl_o = ALU_SLL;
      3'b100:  alu_ctrl_o = ALU_XOR;
      3'b101:  alu_ctrl_o = ALU_SRL;
      3'b110:  alu_ctrl_o = ALU_OR;
      3'b111:  alu_ctrl_o = ALU_AND;
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I-subset core sharing a single
// variable-latency memory port. Steps fetch/decode/execute/memory/writeback
// and drives datapath selects and enables. Memory states time out into a
// sticky ERROR state after WAIT_MAX cycles without mem_ready.
// Optional performance counters are enabled with `define MCTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm
  import mctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16
`ifdef MCTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OPCODE,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       sign_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       err
`ifdef MCTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  // Counter holds at most WAIT_MAX (on the cycle it trips into ERROR).
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_e state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] alu_dec_ctrl;
  logic       mem_state;
  logic       wait_hit;

  mctrl_alu_dec u_alu_dec (
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .sub_en_i   (OPCODE[5]),
    .alu_ctrl_o (alu_dec_ctrl)
  );

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
  // The limit only trips when memory is still not ready on that cycle.
  assign wait_hit  = (wait_cnt_q == WAIT_LAST);

  // State and wait-counter registers; reset aborts any instruction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Wait counter counts stalled memory cycles; any other cycle clears it,
  // so it always starts from zero on entry to a memory state.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Next-state and Moore-style control decode (with the gated exceptions).
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        // Branch/jump target OldPC+imm is parked in ALUOut here.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_sel(OPCODE);
        case (OPCODE)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_sel(OPCODE);
        state_d = (OPCODE == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)     state_d = S_MEMWB;
        else if (wait_hit) state_d = S_ERROR;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready)     state_d = S_FETCH;
        else if (wait_hit) state_d = S_ERROR;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_dec_ctrl;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = alu_dec_ctrl;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_B;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          3'b100:  PCWrite = sign_flag;
          default: PCWrite = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ERROR: err = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

`ifdef MCTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  // Cycle count excludes RESET/ERROR; retire count fires on the last cycle
  // of an instruction, i.e. any transition into FETCH other than from RESET.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_RESET && state_q != S_ERROR) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RESET) begin
      instret_cnt_d = instret_cnt_q + 1'b1;
    end
  end

  // Performance counter registers, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm (WAIT_MAX=4).
// Control outputs are packed into one vector and compared per cycle against
// hand-written expectations. Perf counters are checked when
// MCTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl_fsm;

  localparam int WAIT_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] OPCODE = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic       sign_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, err;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .OPCODE     (OPCODE),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .sign_flag  (sign_flag),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .err        (err)
`ifdef MCTRL_PERF_CNT_EN
    , .cycle_cnt  (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  // {mem_req,MemWrite,IRWrite,PCWrite,AdrSrc,SrcA,SrcB,ResultSrc,ImmSrc,ALUControl,RegWrite,err}
  logic [17:0] ctrl;
  assign ctrl = {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                 ResultSrc, ImmSrc, ALUControl, RegWrite, err};

  localparam logic [17:0] E_ZERO   = 18'd0;
  localparam logic [17:0] E_ERR    = 18'd1;
  localparam logic [17:0] E_F_RDY  = {1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b10,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_F_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DEC_I  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DEC_S  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b01,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DEC_B  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b10,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_DEC_J  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b11,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MADR_L = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MADR_S = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b01,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MEMRD  = {1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_MEMWR  = {1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};
  localparam logic [17:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0};
  localparam logic [17:0] E_JAL    = {1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,2'b00,3'b000,1'b0,1'b0};

  // Non-checking helper: pulse reset and leave the FSM at a negedge in FETCH.
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    OPCODE = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctrl !== E_ZERO) begin
      errors++;
      $display("FAIL reset_low: ctrl=%b expected %b", ctrl, E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctrl !== E_ZERO) begin
      errors++;
      $display("FAIL reset_first_cycle: ctrl=%b expected %b", ctrl, E_ZERO);
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [2:0] f3_t [5];
    logic       f7_t [5];
    logic [2:0] alu_t [5];
    logic [17:0] exp_v [4];
    f3_t  = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b100};
    f7_t  = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    alu_t = '{3'b000, 3'b010, 3'b111, 3'b101, 3'b100};
    for (int k = 0; k < 5; k++) begin
      exp_v[0] = E_F_RDY;
      exp_v[1] = E_DEC_I;
      exp_v[2] = {13'b0000010000000, alu_t[k], 2'b00};
      exp_v[3] = E_ALUWB;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) @(negedge clk);
        OPCODE = 7'b0110011; funct3 = f3_t[k]; funct7 = f7_t[k]; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== exp_v[c]) begin
          errors++;
          $display("FAIL rtype[%0d] cyc%0d: ctrl=%b expected %b", k, c, ctrl, exp_v[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    logic [2:0] f3_t [3];
    logic       f7_t [3];
    logic [2:0] alu_t [3];
    logic [17:0] exp_v [4];
    f3_t  = '{3'b000, 3'b110, 3'b001};
    f7_t  = '{1'b1,   1'b0,   1'b0};
    alu_t = '{3'b000, 3'b110, 3'b001};
    for (int k = 0; k < 3; k++) begin
      exp_v[0] = E_F_RDY;
      exp_v[1] = E_DEC_I;
      exp_v[2] = {13'b0000010010000, alu_t[k], 2'b00};
      exp_v[3] = E_ALUWB;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) @(negedge clk);
        OPCODE = 7'b0010011; funct3 = f3_t[k]; funct7 = f7_t[k]; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== exp_v[c]) begin
          errors++;
          $display("FAIL itype[%0d] cyc%0d: ctrl=%b expected %b", k, c, ctrl, exp_v[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  // lw with three stalled MEMREAD cycles; ready arrives on the limit cycle.
  task automatic test_load_wait();
    logic [17:0] exp_v [8];
    logic        rdy_t [8];
    exp_v = '{E_F_RDY, E_DEC_I, E_MADR_L, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    rdy_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0; mem_ready = rdy_t[c];
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL load_wait cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    logic [17:0] exp_v [4];
    exp_v = '{E_F_RDY, E_DEC_S, E_MADR_S, E_MEMWR};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0; mem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL store cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    @(negedge clk);
  endtask

  // Entries are {funct3, Zero, sign_flag, expected PCWrite}.
  task automatic test_branch();
    logic [5:0] tbl [14];
    logic [17:0] exp_v [3];
    tbl = '{6'b000_00_0, 6'b000_10_1, 6'b000_01_0, 6'b000_11_1,
            6'b001_00_1, 6'b001_10_0, 6'b001_01_1, 6'b001_11_0,
            6'b100_00_0, 6'b100_10_0, 6'b100_01_1, 6'b100_11_1,
            6'b101_11_0, 6'b010_11_0};
    for (int k = 0; k < 14; k++) begin
      exp_v[0] = E_F_RDY;
      exp_v[1] = E_DEC_B;
      exp_v[2] = {3'b000, tbl[k][0], 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b010, 2'b00};
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        OPCODE = 7'b1100011; funct3 = tbl[k][5:3]; funct7 = 1'b0;
        Zero = tbl[k][2]; sign_flag = tbl[k][1]; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== exp_v[c]) begin
          errors++;
          $display("FAIL branch[%0d] cyc%0d: ctrl=%b expected %b", k, c, ctrl, exp_v[c]);
        end
      end
      @(negedge clk);
    end
    Zero = 1'b0; sign_flag = 1'b0;
  endtask

  task automatic test_jal();
    logic [17:0] exp_v [4];
    exp_v = '{E_F_RDY, E_DEC_J, E_JAL, E_ALUWB};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b1101111; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL jal cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [17:0] exp_v [4];
    exp_v = '{E_F_RDY, E_DEC_I, E_ERR, E_ERR};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b0000000; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL illegal cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    pulse_reset();
  endtask

  // FETCH never gets mem_ready: four stalled cycles then sticky ERROR.
  task automatic test_fetch_timeout();
    logic [17:0] exp_v [7];
    logic        rdy_t [7];
    exp_v = '{E_F_WAIT, E_F_WAIT, E_F_WAIT, E_F_WAIT, E_ERR, E_ERR, E_ERR};
    rdy_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0; mem_ready = rdy_t[c];
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL fetch_timeout cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    pulse_reset();
  endtask

  // Reset in the middle of a stalled store must drop MemWrite immediately.
  task automatic test_reset_mid_store();
    logic [17:0] exp_v [4];
    logic        rdy_t [4];
    exp_v = '{E_F_RDY, E_DEC_S, E_MADR_S, E_MEMWR};
    rdy_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      OPCODE = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0; mem_ready = rdy_t[c];
      #1;
      checks++;
      if (ctrl !== exp_v[c]) begin
        errors++;
        $display("FAIL mid_store cyc%0d: ctrl=%b expected %b", c, ctrl, exp_v[c]);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== E_ZERO) begin
      errors++;
      $display("FAIL mid_store_abort: ctrl=%b expected %b", ctrl, E_ZERO);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctrl !== E_ZERO) begin
      errors++;
      $display("FAIL mid_store_reset_state: ctrl=%b expected %b", ctrl, E_ZERO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctrl !== E_F_RDY) begin
      errors++;
      $display("FAIL mid_store_refetch: ctrl=%b expected %b", ctrl, E_F_RDY);
    end
    @(negedge clk);
    // one cycle in DECODE is harmless; return to a clean FETCH via reset
    pulse_reset();
  endtask

`ifdef MCTRL_PERF_CNT_EN
  task automatic test_perf();
    pulse_reset();
    OPCODE = 7'b0010011; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: cycle=%0d instret=%0d expected 0 0", cycle_cnt, instret_cnt);
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (cycle_cnt !== 32'd40 || instret_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_10_addi: cycle=%0d instret=%0d expected 40 10", cycle_cnt, instret_cnt);
    end
    checks++;
    if (ctrl !== E_F_RDY) begin
      errors++;
      $display("FAIL perf_end_state: ctrl=%b expected %b", ctrl, E_F_RDY);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store();
    test_branch();
    test_jal();
    test_illegal();
    test_fetch_timeout();
    test_reset_mid_store();
`ifdef MCTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
